// File: rtl/polytris_pkg.sv
// -----------------------------------------------------------------------------
// polytris_pkg
// Types and constants shared by the level tracker and its BCD digit
// incrementer.
//   level_t         : 3-bit level. It selects the block-colour palette.
//   bcd_digit_t     : one packed BCD digit.
//   BCD_MAX         : saturation value of the 3-digit line total.
//   tracker_state_t : IDLE (ready for an event) / ADD (consuming lines).
// -----------------------------------------------------------------------------
package polytris_pkg;

   typedef logic [2:0] level_t;
   typedef logic [3:0] bcd_digit_t;

   localparam logic [11:0] BCD_MAX = 12'h999;

   typedef enum logic {
      IDLE = 1'b0,
      ADD  = 1'b1
   } tracker_state_t;

endpackage

// File: rtl/bcd_digit_inc.sv
// -----------------------------------------------------------------------------
// bcd_digit_inc
// Combinational increment of one BCD digit. Chain the instances through
// cin_i/cout_o to build a multi-digit counter.
// Ports:
//   digit_i : input BCD digit (0..9)
//   cin_i   : increment request / carry in from the lower digit
//   digit_o : resulting digit
//   cout_o  : carry out (digit rolled over from 9 to 0)
// -----------------------------------------------------------------------------
module bcd_digit_inc
   import polytris_pkg::*;
(
   input  bcd_digit_t digit_i,
   input  logic       cin_i,
   output bcd_digit_t digit_o,
   output logic       cout_o
);

   always_comb begin
      cout_o  = cin_i && (digit_i == 4'd9);
      digit_o = digit_i;
      if (cin_i) begin
         digit_o = (digit_i == 4'd9) ? 4'd0 : digit_i + 4'd1;
      end
   end

endmodule

// File: rtl/level_tracker.sv
// -----------------------------------------------------------------------------
// level_tracker
// Counts cleared lines and produces the 3-bit level that selects the
// block-colour palette. It accepts line-clear events of 1..MAX_CLEAR lines.
// The lines are added one per cycle to a 3-digit BCD total that the HUD shows.
// A level_up pulse tells the renderer to latch the new palette.
//
// Optional feature macro: LEVEL_WRAP_EN
//   defined   : level 7 advances to 0, and level_up still pulses.
//   undefined : level saturates at 7, and level_up stays low once there.
//               The per-level line counter still wraps.
//
// Ports:
//   Clk          : system clock
//   Reset        : synchronous, active-high reset
//   game_start   : 1-cycle pulse. Loads start_level and clears all counts.
//                  It has priority over everything else.
//   start_level  : level loaded on game_start
//   clear_valid  : line-clear event valid
//   clear_count  : lines in the event. Values above MAX_CLEAR are clamped.
//   clear_ready  : high while an event can be accepted (state IDLE)
//   level        : current level (registered)
//   lines_bcd    : total lines as {hundreds, tens, ones} BCD (registered)
//   level_up     : 1-cycle pulse on the edge where the line count changes
//                  the level (registered)
// -----------------------------------------------------------------------------
module level_tracker
   import polytris_pkg::*;
#(
   parameter int unsigned LINES_PER_LEVEL = 10,
   parameter int unsigned MAX_CLEAR       = 4
)
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        game_start,
   input  logic [2:0]  start_level,
   input  logic        clear_valid,
   input  logic [2:0]  clear_count,
   output logic        clear_ready,
   output logic [2:0]  level,
   output logic [11:0] lines_bcd,
   output logic        level_up
);

   localparam logic [2:0] MAX_CLEAR_W = 3'(MAX_CLEAR);
   localparam logic [3:0] LVL_LAST    = 4'(LINES_PER_LEVEL - 1);

   tracker_state_t state_q, state_d;
   logic [2:0]     rem_q, rem_d;
   level_t         level_q, level_d;
   logic [11:0]    lines_q, lines_d;
   logic [3:0]     lvl_cnt_q, lvl_cnt_d;
   logic           level_up_q, level_up_d;

   logic [2:0]     clamped_count;
   logic [11:0]    lines_inc;
   logic [3:0]     carry;

   assign clamped_count = (clear_count > MAX_CLEAR_W) ? MAX_CLEAR_W : clear_count;

   // Ripple the +1 through the ones, tens and hundreds digits.
   // The result is only used below BCD_MAX, so the top carry-out is ignored.
   assign carry[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit
         bcd_digit_inc u_digit (
            .digit_i (lines_q[gi*4 +: 4]),
            .cin_i   (carry[gi]),
            .digit_o (lines_inc[gi*4 +: 4]),
            .cout_o  (carry[gi+1])
         );
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      level_d    = level_q;
      lines_d    = lines_q;
      lvl_cnt_d  = lvl_cnt_q;
      level_up_d = 1'b0;

      if (game_start) begin
         // Drops any event in progress or presented this cycle.
         state_d   = IDLE;
         rem_d     = 3'd0;
         level_d   = start_level;
         lines_d   = 12'h000;
         lvl_cnt_d = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clear_valid && (clamped_count != 3'd0)) begin
                  rem_d   = clamped_count;
                  state_d = ADD;
               end
            end
            ADD: begin
               rem_d = rem_q - 3'd1;
               if (rem_q == 3'd1) begin
                  state_d = IDLE;
               end
               // At saturation the line is still consumed, but nothing counts.
               if (lines_q != BCD_MAX) begin
                  lines_d = lines_inc;
                  if (lvl_cnt_q == LVL_LAST) begin
                     lvl_cnt_d = 4'd0;
`ifdef LEVEL_WRAP_EN
                     level_d    = level_q + 3'd1;
                     level_up_d = 1'b1;
`else
                     if (level_q != 3'd7) begin
                        level_d    = level_q + 3'd1;
                        level_up_d = 1'b1;
                     end
`endif
                  end else begin
                     lvl_cnt_d = lvl_cnt_q + 4'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         rem_q      <= 3'd0;
         level_q    <= 3'd0;
         lines_q    <= 12'h000;
         lvl_cnt_q  <= 4'd0;
         level_up_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         level_q    <= level_d;
         lines_q    <= lines_d;
         lvl_cnt_q  <= lvl_cnt_d;
         level_up_q <= level_up_d;
      end
   end

   assign clear_ready = (state_q == IDLE);
   assign level       = level_q;
   assign lines_bcd   = lines_q;
   assign level_up    = level_up_q;

endmodule

// File: tb/tb_level_tracker.sv
// -----------------------------------------------------------------------------
// tb_level_tracker
// Directed bench for level_tracker. A behavioural model holds the line total
// as a plain integer and the pending work as a line count. One compare process
// checks every output against this model on each negedge. Hand-computed
// literal expectations pin the model at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_level_tracker;

   localparam int LPL = 10;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        game_start = 1'b0;
   logic [2:0]  start_level = 3'd0;
   logic        clear_valid = 1'b0;
   logic [2:0]  clear_count = 3'd0;
   logic        clear_ready;
   logic [2:0]  level;
   logic [11:0] lines_bcd;
   logic        level_up;

   int n_checks = 0;
   int n_fail   = 0;
   int lu_total = 0;

   // Behavioural model state.
   int   m_level   = 0;
   int   m_total   = 0;
   int   m_cnt     = 0;
   int   m_pending = 0;
   logic m_lu      = 1'b0;
   logic m_valid   = 1'b0;

   level_tracker #(.LINES_PER_LEVEL(LPL), .MAX_CLEAR(4)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .game_start  (game_start),
      .start_level (start_level),
      .clear_valid (clear_valid),
      .clear_count (clear_count),
      .clear_ready (clear_ready),
      .level       (level),
      .lines_bcd   (lines_bcd),
      .level_up    (level_up)
   );

   always #5 Clk = ~Clk;

   function automatic int to_bcd(input int v);
      return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each accepted event becomes a number of pending lines, and one
   // line is drained per cycle.
   always @(posedge Clk) begin : model
      int lv, tot, cnt, pend;
      logic lu;
      lv = m_level; tot = m_total; cnt = m_cnt; pend = m_pending; lu = 1'b0;
      if (Reset) begin
         lv = 0; tot = 0; cnt = 0; pend = 0;
      end else if (game_start) begin
         lv = int'(start_level); tot = 0; cnt = 0; pend = 0;
      end else if (pend > 0) begin
         pend = pend - 1;
         if (tot < 999) begin
            tot = tot + 1;
            cnt = cnt + 1;
            if (cnt == LPL) begin
               cnt = 0;
`ifdef LEVEL_WRAP_EN
               lv = (lv + 1) % 8;
               lu = 1'b1;
`else
               if (lv < 7) begin
                  lv = lv + 1;
                  lu = 1'b1;
               end
`endif
            end
         end
      end else if (clear_valid) begin
         pend = (int'(clear_count) > 4) ? 4 : int'(clear_count);
      end
      m_level   <= lv;
      m_total   <= tot;
      m_cnt     <= cnt;
      m_pending <= pend;
      m_lu      <= lu;
      m_valid   <= 1'b1;
   end

   always @(negedge Clk) begin
      if (m_valid) begin
         check("level",       int'(level),       m_level);
         check("lines_bcd",   int'(lines_bcd),   to_bcd(m_total));
         check("level_up",    int'(level_up),    int'(m_lu));
         check("clear_ready", int'(clear_ready), (m_pending == 0) ? 1 : 0);
      end
   end

   always @(negedge Clk) begin
      if (level_up === 1'b1) lu_total <= lu_total + 1;
   end

   task automatic do_start(input int lvl);
      @(negedge Clk);
      game_start  = 1'b1;
      start_level = 3'(lvl);
      @(negedge Clk);
      game_start  = 1'b0;
   endtask

   // Presents one event and waits for ready to return. low_cycles is the
   // number of negedges at which clear_ready was seen low.
   task automatic do_event(input int cc, output int low_cycles);
      @(negedge Clk);
      clear_valid = 1'b1;
      clear_count = 3'(cc);
      @(negedge Clk);
      clear_valid = 1'b0;
      low_cycles  = 0;
      while (!clear_ready && low_cycles < 20) begin
         low_cycles++;
         @(negedge Clk);
      end
      if (low_cycles >= 20) check("ready_timeout", 0, 1);
   endtask

   initial begin
      int low, lu0;

      // Reset
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      check("rst_level", int'(level), 0);
      check("rst_lines", int'(lines_bcd), 12'h000);
      check("rst_ready", int'(clear_ready), 1);
      check("rst_lu",    int'(level_up), 0);

      // 1: game start at level 3
      do_start(3);
      check("t1_level", int'(level), 3);
      check("t1_lines", int'(lines_bcd), 12'h000);
      check("t1_ready", int'(clear_ready), 1);

      // 2: 4 + 1 + 4 + 1 lines -> 010, level 4, one pulse
      lu0 = lu_total;
      do_event(4, low);
      check("t2_low4",  low, 4);
      check("t2_lines", int'(lines_bcd), 12'h004);
      do_event(1, low);
      do_event(4, low);
      do_event(1, low);
      @(negedge Clk);
      check("t2_lines10", int'(lines_bcd), 12'h010);
      check("t2_level",   int'(level), 4);
      check("t2_pulses",  lu_total - lu0, 1);

      // 3: reach 998, then saturate at 999
      do_start(0);
      for (int i = 0; i < 249; i++) do_event(4, low);
      do_event(2, low);
      check("t3_lines998", int'(lines_bcd), 12'h998);
      lu0 = lu_total;
      do_event(4, low);
      check("t3_low4",   low, 4);
      check("t3_lines",  int'(lines_bcd), 12'h999);
      do_event(3, low);
      @(negedge Clk);
      check("t3_low3",   low, 3);
      check("t3_sat",    int'(lines_bcd), 12'h999);
      check("t3_pulses", lu_total - lu0, 0);

      // 4: level 7 plus 10 lines
      do_start(7);
      lu0 = lu_total;
      do_event(4, low);
      do_event(4, low);
      do_event(2, low);
      @(negedge Clk);
      check("t4_lines", int'(lines_bcd), 12'h010);
`ifdef LEVEL_WRAP_EN
      check("t4_level",  int'(level), 0);
      check("t4_pulses", lu_total - lu0, 1);
`else
      check("t4_level",  int'(level), 7);
      check("t4_pulses", lu_total - lu0, 0);
`endif

      // 5: game_start on the 2nd ADD cycle of a 3-line clear
      do_start(2);
      @(negedge Clk);
      clear_valid = 1'b1;
      clear_count = 3'd3;
      @(negedge Clk);
      clear_valid = 1'b0;
      @(negedge Clk);
      check("t5_mid", int'(lines_bcd), 12'h001);
      game_start  = 1'b1;
      start_level = 3'd5;
      @(negedge Clk);
      game_start  = 1'b0;
      check("t5_ready", int'(clear_ready), 1);
      check("t5_lines", int'(lines_bcd), 12'h000);
      check("t5_level", int'(level), 5);
      repeat (3) @(negedge Clk);
      check("t5_still", int'(lines_bcd), 12'h000);

      // 6: zero count, clamped count, event colliding with game_start
      @(negedge Clk);
      clear_valid = 1'b1;
      clear_count = 3'd0;
      @(negedge Clk);
      clear_valid = 1'b0;
      check("t6_zero_ready", int'(clear_ready), 1);
      @(negedge Clk);
      check("t6_zero_lines", int'(lines_bcd), 12'h000);
      do_event(7, low);
      check("t6_clamp_low",   low, 4);
      check("t6_clamp_lines", int'(lines_bcd), 12'h004);
      @(negedge Clk);
      game_start  = 1'b1;
      start_level = 3'd1;
      clear_valid = 1'b1;
      clear_count = 3'd3;
      @(negedge Clk);
      game_start  = 1'b0;
      clear_valid = 1'b0;
      check("t6_drop_ready", int'(clear_ready), 1);
      repeat (4) @(negedge Clk);
      check("t6_drop_lines", int'(lines_bcd), 12'h000);
      check("t6_drop_level", int'(level), 1);

      // Reset asserted mid-ADD
      do_start(6);
      @(negedge Clk);
      clear_valid = 1'b1;
      clear_count = 3'd4;
      @(negedge Clk);
      clear_valid = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("rst2_level", int'(level), 0);
      check("rst2_lines", int'(lines_bcd), 12'h000);
      check("rst2_ready", int'(clear_ready), 1);
      repeat (3) @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
